prf_nway: RTL
=============

PRF_NWAY -- requirements
Module: prf_nway

Interface
REQ-001 SHALL have parameter PRF_SIZE, default 64: physical registers.
REQ-002 SHALL have parameter ARF_SIZE, default 32: architectural registers.
REQ-003 SHALL have parameter WAYS, default 2: allocate/CDB/retire ports.
REQ-004 SHALL have parameter DATA_W, default 64: register data width.
REQ-005 SHALL use reset reset, synchronous, active-high; clock clock.
REQ-006 SHALL have: clock  in  1  rising-edge clock.
REQ-007 SHALL have: reset  in  1  synchronous active-high reset.
REQ-008 SHALL have: cdb_en  in  WAYS  per-port writeback strobe.
REQ-009 SHALL have: cdb_tag  in  WAYS x PRF_IDX  writeback register.
REQ-010 SHALL have: cdb_value  in  WAYS x DATA_W  writeback data.
REQ-011 SHALL have: alloc_req  in  WAYS  per-way rename request.
REQ-012 SHALL have: retire_valid  in  WAYS  per-port free request.
REQ-013 SHALL have: retire_tag  in  WAYS x PRF_IDX  register to free.
REQ-014 SHALL have: flush  in  1  restore from retirement map.
REQ-015 SHALL have: rrat_map  in  ARF_SIZE x PRF_IDX  retired mapping.
REQ-016 SHALL have: alloc_reg  out  WAYS x PRF_IDX  register granted per way.
REQ-017 SHALL have: alloc_stall  out  1  requests exceed free registers.
REQ-018 SHALL have: prf_values  out  PRF_SIZE x DATA_W  register contents.
REQ-019 SHALL have: prf_valid  out  PRF_SIZE  value-ready bits.
REQ-020 SHALL have: free_count  out  clog2(PRF_SIZE+1)  free registers.
REQ-021 SHALL have: prf_free  out  PRF_SIZE  free bitmap (debug).

Function
REQ-022 Allocation SHALL be combinational: way i receives the k-th lowest free index, k = count of asserted alloc_req below i.
REQ-023 alloc_reg SHALL be 0 for ways without alloc_req.
REQ-024 alloc_stall SHALL assert when popcount(alloc_req) > free_count; stall SHALL be all-or-nothing, with no register consumed.
REQ-025 A granted register SHALL become not-free and not-valid at the next edge.
REQ-026 A retire SHALL set free and clear valid at the next edge; freed registers SHALL NOT be grantable in the same cycle.
REQ-027 A CDB write SHALL update value and set valid at the next edge; duplicate tags SHALL resolve to the highest port.
REQ-028 On the same tag, CDB valid-set SHALL override allocate/retire valid-clear.
REQ-029 free_count SHALL equal popcount(prf_free), combinational from state.
REQ-030 Flush SHALL set free to the complement of rrat_map membership and valid to old valid ANDed with membership; alloc_req and retire SHALL be ignored.
REQ-031 A CDB write during flush SHALL update value, setting valid only if the tag is in rrat_map.
REQ-032 Zero free registers SHALL give alloc_stall for any nonzero request and never a duplicate grant.

Reset
REQ-033 Reset SHALL dominate flush and all other inputs.
REQ-034 On reset, registers 0..ARF_SIZE-1 SHALL be not-free and valid, registers ARF_SIZE..PRF_SIZE-1 SHALL be free and not-valid, and all values SHALL be 0.
REQ-035 Reset mid-operation SHALL discard pending grants; the outputs after reset SHALL be alloc_reg 0 for all ways, alloc_stall 0 and free_count PRF_SIZE-ARF_SIZE.

Configuration
REQ-036 Macro PRF_CDB_BYPASS_EN defined: prf_values/prf_valid SHALL reflect same-cycle CDB writes combinationally (highest port wins).
REQ-037 Macro PRF_CDB_BYPASS_EN undefined: CDB writes SHALL be visible only after the next edge.

Structure
REQ-038 Package prf_pkg SHALL hold PRF_SIZE, ARF_SIZE, WAYS, DATA_W, PRF_IDX = clog2(PRF_SIZE) and typedef prf_tag_t.
REQ-039 Sub-module prf_free_sel SHALL find the WAYS lowest set bits of the free bitmap with per-slot found flags.

Verification
REQ-040 Reset, alloc_req=2'b11 -> alloc_reg {32,33}, free_count 32; next cycle prf_valid[32]=prf_valid[33]=0, free_count 30.
REQ-041 alloc_req=2'b10 -> way1 gets 32, way0 alloc_reg 0; alloc_req=2'b11 with free_count 1 -> alloc_stall=1 and prf_free unchanged.
REQ-042 Dual CDB writes, tag 40: port0 0xA, port1 0xB -> next cycle value 0xB, valid 1; with bypass enabled, visible in the same cycle.
REQ-043 Retire tag 5 together with alloc_req on the last free register -> 5 is not granted that cycle; next cycle prf_free[5]=1 and prf_valid[5]=0.
REQ-044 Flush with rrat_map = identity except arch 3 -> 50 (50 valid, 3 valid) -> prf_free[3]=1, prf_free[50]=0, prf_valid[50]=1, prf_valid[3]=0.
REQ-045 Flush and reset asserted together -> reset state of REQ-034.

Source files
------------

// File: rtl/prf_pkg.sv
// Physical register file shared definitions.
// Holds the default geometry of the renamed register file and the tag type
// used to name a physical register. Modules take these as parameter
// defaults so a different geometry can still be built per instance.
package prf_pkg;
  localparam int PRF_SIZE = 64;                 // physical registers
  localparam int ARF_SIZE = 32;                 // architectural registers
  localparam int WAYS     = 2;                  // allocate / CDB / retire ports
  localparam int DATA_W   = 64;                 // register data width
  localparam int PRF_IDX  = $clog2(PRF_SIZE);   // physical tag width

  typedef logic [PRF_IDX-1:0] prf_tag_t;
endpackage

// File: rtl/prf_free_sel.sv
// Lowest-free-register finder.
// Scans the free bitmap from index 0 upward and reports the WAYS lowest set
// bits in ascending order: sel[0] is the lowest free index, sel[1] the next,
// and so on. found[k] tells whether slot k holds a real index; when fewer
// than WAYS bits are set the remaining slots read 0 with found cleared.
// Ports:
//   free  in  N           free bitmap
//   sel   out WAYS x IDX_W  k-th lowest free index
//   found out WAYS        slot k is populated
module prf_free_sel import prf_pkg::*; #(
  parameter int N     = PRF_SIZE,
  parameter int WAYS  = prf_pkg::WAYS,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]                  free,
  output logic [WAYS-1:0][IDX_W-1:0]    sel,
  output logic [WAYS-1:0]               found
);

  always_comb begin
    int cnt;
    sel   = '0;
    found = '0;
    cnt   = 0;
    for (int i = 0; i < N; i++) begin
      if (free[i]) begin
        for (int k = 0; k < WAYS; k++) begin
          if (cnt == k) begin
            sel[k]   = IDX_W'(i);
            found[k] = 1'b1;
          end
        end
        cnt++;
      end
    end
  end

endmodule

// File: rtl/prf_nway.sv
// N-way physical register file with free list.
// Grants free physical registers to rename ways, accepts CDB writebacks,
// frees registers on retirement and rebuilds the free/valid state from the
// retirement map on a flush.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   cdb_en/tag/value  per-port writeback (highest port wins on equal tags)
//   alloc_req         per-way rename request
//   retire_valid/tag  per-port register free request
//   flush, rrat_map   restore state from the retired mapping
//   alloc_reg         register granted per way (0 when not granted)
//   alloc_stall       requests exceed free registers; nothing is granted
//   prf_values/valid  register contents and value-ready bits
//   free_count        number of free registers
//   prf_free          free bitmap
//
// Optional feature: define PRF_CDB_BYPASS_EN to make same-cycle CDB writes
// visible combinationally on prf_values/prf_valid. Without it a writeback is
// visible only after the next edge.
//
// Handshake: alloc_req is a request without back-pressure; a way is granted
// in the same cycle it requests unless alloc_stall is high, in which case no
// way is granted and the requester must hold its request and retry.
module prf_nway import prf_pkg::*; #(
  parameter int PRF_SIZE = prf_pkg::PRF_SIZE,
  parameter int ARF_SIZE = prf_pkg::ARF_SIZE,
  parameter int WAYS     = prf_pkg::WAYS,
  parameter int DATA_W   = prf_pkg::DATA_W,
  localparam int IDX_W   = $clog2(PRF_SIZE),
  localparam int CNT_W   = $clog2(PRF_SIZE + 1)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [WAYS-1:0]                     cdb_en,
  input  logic [WAYS-1:0][IDX_W-1:0]          cdb_tag,
  input  logic [WAYS-1:0][DATA_W-1:0]         cdb_value,
  input  logic [WAYS-1:0]                     alloc_req,
  input  logic [WAYS-1:0]                     retire_valid,
  input  logic [WAYS-1:0][IDX_W-1:0]          retire_tag,
  input  logic                                flush,
  input  logic [ARF_SIZE-1:0][IDX_W-1:0]      rrat_map,
  output logic [WAYS-1:0][IDX_W-1:0]          alloc_reg,
  output logic                                alloc_stall,
  output logic [PRF_SIZE-1:0][DATA_W-1:0]     prf_values,
  output logic [PRF_SIZE-1:0]                 prf_valid,
  output logic [CNT_W-1:0]                    free_count,
  output logic [PRF_SIZE-1:0]                 prf_free
);

  logic [PRF_SIZE-1:0]               free_q, free_d;
  logic [PRF_SIZE-1:0]               valid_q, valid_d;
  logic [PRF_SIZE-1:0][DATA_W-1:0]   values_q, values_d;
  logic [WAYS-1:0][IDX_W-1:0]        sel;
  logic [WAYS-1:0]                   found;
  logic [WAYS-1:0]                   grant_en;
  logic [CNT_W-1:0]                  req_cnt;
  logic [PRF_SIZE-1:0]               member;

  // Candidates come from the registered free bitmap only, so a register
  // retired this cycle cannot be handed out until the next cycle.
  prf_free_sel #(.N(PRF_SIZE), .WAYS(WAYS), .IDX_W(IDX_W)) u_free_sel (
    .free  (free_q),
    .sel   (sel),
    .found (found)
  );

  always_comb begin
    free_count = '0;
    for (int r = 0; r < PRF_SIZE; r++) free_count = free_count + CNT_W'(free_q[r]);
    req_cnt = '0;
    for (int w = 0; w < WAYS; w++) req_cnt = req_cnt + CNT_W'(alloc_req[w]);
  end

  assign alloc_stall = !reset && (req_cnt > free_count);

  // Way w takes the k-th lowest free register, k = requests on lower ways.
  // Stall, flush and reset suppress every grant so nothing is consumed.
  always_comb begin
    int k;
    alloc_reg = '0;
    grant_en  = '0;
    k         = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (alloc_req[w]) begin
        for (int j = 0; j < WAYS; j++) begin
          if (k == j && found[j] && !alloc_stall && !flush && !reset) begin
            alloc_reg[w] = sel[j];
            grant_en[w]  = 1'b1;
          end
        end
        k++;
      end
    end
  end

  // Physical registers named by the retirement map.
  always_comb begin
    member = '0;
    for (int r = 0; r < PRF_SIZE; r++)
      for (int a = 0; a < ARF_SIZE; a++)
        if (rrat_map[a] == IDX_W'(r)) member[r] = 1'b1;
  end

  // CDB updates are applied last so a writeback's valid-set overrides the
  // valid-clear of an allocate or retire to the same tag.
  always_comb begin
    free_d   = free_q;
    valid_d  = valid_q;
    values_d = values_q;
    if (flush) begin
      free_d  = ~member;
      valid_d = valid_q & member;
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        if (retire_valid[w]) begin
          free_d[retire_tag[w]]  = 1'b1;
          valid_d[retire_tag[w]] = 1'b0;
        end
      end
      for (int w = 0; w < WAYS; w++) begin
        if (grant_en[w]) begin
          free_d[alloc_reg[w]]  = 1'b0;
          valid_d[alloc_reg[w]] = 1'b0;
        end
      end
    end
    for (int p = 0; p < WAYS; p++) begin
      if (cdb_en[p]) begin
        values_d[cdb_tag[p]] = cdb_value[p];
        if (!flush || member[cdb_tag[p]]) valid_d[cdb_tag[p]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < PRF_SIZE; r++) begin
        free_q[r]  <= (r >= ARF_SIZE);
        valid_q[r] <= (r < ARF_SIZE);
      end
      values_q <= '0;
    end else begin
      free_q   <= free_d;
      valid_q  <= valid_d;
      values_q <= values_d;
    end
  end

  assign prf_free = free_q;

`ifdef PRF_CDB_BYPASS_EN
  always_comb begin
    prf_values = values_q;
    prf_valid  = valid_q;
    for (int p = 0; p < WAYS; p++) begin
      if (cdb_en[p]) begin
        prf_values[cdb_tag[p]] = cdb_value[p];
        prf_valid[cdb_tag[p]]  = 1'b1;
      end
    end
  end
`else
  assign prf_values = values_q;
  assign prf_valid  = valid_q;
`endif

endmodule
